muldiv_sequencer: RTL

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting in the execute stage beside the main ALU. The decoder routes `funct7 == 7'b0000001` R-type instructions here instead of to the ALU. The block captures operands, runs one shift-add or restoring-divide step per cycle, and stalls the pipeline until the result is ready. It returns a one-cycle `done` pulse with the 32-bit result.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M multiply/divide unit.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output start, flush, Funct3, SrcA, SrcB,
        input  busy, stall, done, Result
    );

    modport slave (
        input  start, flush, Funct3, SrcA, SrcB,
        output busy, stall, done, Result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/DIV unit: one shift-add or restoring-divide step per cycle, sign fix-up at DONE entry.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish in one cycle.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e            state_q;
    logic [2:0]        funct3_q;
    logic              a_neg_q;
    logic              b_neg_q;
    logic              div0_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opa_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   result_q;
    logic              busy_q;
    logic              done_q;

    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   opa_d;
    logic [XLEN-1:0]   opb_d;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic              a_neg_in;
    logic              b_neg_in;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Sign fix-up and result selection; overflow (INT_MIN / -1) falls out of the magnitude path naturally.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0]        f3,
                                                 input logic [2*XLEN-1:0] acc,
                                                 input logic              an,
                                                 input logic              bn,
                                                 input logic              dz);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = (an ^ bn) ? -acc : acc;
        quo  = (an ^ bn) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = an ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (dz) quo = '1;
        case (f3)
            3'b000:                 return prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return quo;
            default:                return rem;
        endcase
    endfunction

    always_comb begin
        a_neg_in = bus.SrcA[XLEN-1] && (bus.Funct3 == 3'b001 || bus.Funct3 == 3'b010 ||
                                        bus.Funct3 == 3'b100 || bus.Funct3 == 3'b110);
        b_neg_in = bus.SrcB[XLEN-1] && (bus.Funct3 == 3'b001 || bus.Funct3 == 3'b100 ||
                                        bus.Funct3 == 3'b110);
    end

    // One iteration: MUL adds into the upper half then shifts right; DIV shifts the dividend into the remainder.
    always_comb begin
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        if (state_q == S_MUL) begin
            sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
            acc_d = {sum, acc_q[XLEN-1:1]};
            opb_d = opb_q >> 1;
        end else begin
            rem_sh = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
            diff   = rem_sh - {1'b0, opb_q};
            if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            opa_d = opa_q << 1;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_res;

    always_comb begin
        early_hit = 1'b0;
        early_res = '0;
        if (!bus.Funct3[2]) begin
            early_hit = (bus.SrcA == '0) || (bus.SrcB == '0);
        end else if (bus.SrcB == '0) begin
            early_hit = 1'b1;
            early_res = bus.Funct3[1] ? bus.SrcA : '1;
        end else if (!bus.Funct3[0] && bus.SrcA == INT_MIN && bus.SrcB == '1) begin
            early_hit = 1'b1;
            early_res = bus.Funct3[1] ? '0 : bus.SrcA;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.flush) begin
                        funct3_q <= bus.Funct3;
                        a_neg_q  <= a_neg_in;
                        b_neg_q  <= b_neg_in;
                        div0_q   <= bus.Funct3[2] && (bus.SrcB == '0);
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        opa_q    <= mag(bus.SrcA, a_neg_in);
                        opb_q    <= mag(bus.SrcB, b_neg_in);
                        busy_q   <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            state_q  <= S_DONE;
                            result_q <= early_res;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= bus.Funct3[2] ? S_DIV : S_MUL;
                        end
`else
                        state_q <= bus.Funct3[2] ? S_DIV : S_MUL;
`endif
                    end
                end
                S_MUL, S_DIV: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        opa_q <= opa_d;
                        opb_q <= opb_d;
                        if (cnt_q == CNT_LAST) begin
                            state_q  <= S_DONE;
                            result_q <= finalize(funct3_q, acc_d, a_neg_q, b_neg_q, div0_q);
                            done_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall  = (state_q == S_IDLE && bus.start && !bus.flush) ||
                        state_q == S_MUL || state_q == S_DIV;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;
endmodule
